// File: rtl/ifu_pkg.sv
// Shared constants for the instruction fetch unit.
//   IFU_XLEN      default datapath / PC width
//   IFU_RESET_PC  default PC loaded by reset (truncated to XLEN by the user)
//   IFU_*         fetch FSM state encodings (3 bits)
//   ILEN_BYTES    size of one instruction word in bytes
package ifu_pkg;

  localparam int unsigned IFU_XLEN     = 64;
  localparam logic [63:0] IFU_RESET_PC = 64'h8000_0000;
  localparam int unsigned ILEN_BYTES   = 4;

  localparam logic [2:0] IFU_IDLE = 3'd0;
  localparam logic [2:0] IFU_REQ  = 3'd1;
  localparam logic [2:0] IFU_WAIT = 3'd2;
  localparam logic [2:0] IFU_OUT  = 3'd3;
  localparam logic [2:0] IFU_HALT = 3'd4;

  // A redirect target that is not word aligned.
  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return |low_bits;
  endfunction

endpackage

// File: rtl/ifu.sv
// Instruction fetch unit. Owns the PC, issues one fetch at a time to instruction
// memory and hands each fetched word (with its PC) to the decoder.
//   clk, rst_n                   clock, asynchronous active-low reset
//   imem_req_valid/ready/addr    fetch request toward instruction memory
//   imem_rsp_valid/data          fetch response (one per accepted request)
//   instr_valid/ready, instr,    decoded-side handshake; instr/instr_pc are held
//   instr_pc                     stable until accepted
//   redirect_valid, redirect_pc  taken branch/jump from execute
//   halt                         ebreak from the decoder, sampled at the handshake
//   misalign                     sticky flag: a redirect target had low bits set
//   halted                       fetch has stopped until reset
module ifu
  import ifu_pkg::*;
#(
  parameter int unsigned XLEN     = IFU_XLEN,
  parameter logic [63:0] RESET_PC = IFU_RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  output logic            misalign,
  output logic            halted
);

  logic [2:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic            misalign_q, misalign_d;
  logic            redir;

  // Redirects only matter while a fetch is in progress.
  assign redir = redirect_valid &&
                 (state_q == IFU_REQ || state_q == IFU_WAIT || state_q == IFU_OUT);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drop_d     = drop_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    misalign_d = misalign_q;

    if (redir) begin
      pc_d       = {redirect_pc[XLEN-1:2], 2'b00};
      misalign_d = misalign_q | is_misaligned(redirect_pc[1:0]);
    end

    case (state_q)
      IFU_IDLE: state_d = IFU_REQ;
      IFU_REQ: begin
        if (imem_req_ready) begin
          state_d = IFU_WAIT;
          // The accepted request targets the old PC; its response must be thrown away.
          drop_d  = redir;
        end
      end
      IFU_WAIT: begin
        if (imem_rsp_valid) begin
          if (drop_q || redir) begin
            drop_d  = 1'b0;
            state_d = IFU_REQ;
          end else begin
            instr_d    = imem_rsp_data;
            instr_pc_d = pc_q;
            state_d    = IFU_OUT;
          end
        end else if (redir) begin
          drop_d = 1'b1;
        end
      end
      IFU_OUT: begin
        if (instr_ready && halt) begin
          state_d = IFU_HALT;
        end else if (instr_ready) begin
          state_d = IFU_REQ;
          if (!redir) pc_d = pc_q + XLEN'(ILEN_BYTES);
        end else if (redir) begin
          state_d = IFU_REQ;
        end
      end
      IFU_HALT: state_d = IFU_HALT;
      default:  state_d = IFU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IFU_IDLE;
      pc_q       <= XLEN'(RESET_PC);
      drop_q     <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drop_q     <= drop_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      misalign_q <= misalign_d;
    end
  end

  // Everything except halted reads as zero once stopped.
  always_comb begin
    imem_req_valid = (state_q == IFU_REQ);
    imem_req_addr  = (state_q == IFU_REQ) ? pc_q : '0;
    instr_valid    = (state_q == IFU_OUT);
    instr          = (state_q == IFU_OUT) ? instr_q : '0;
    instr_pc       = (state_q == IFU_OUT) ? instr_pc_q : '0;
    misalign       = misalign_q && (state_q != IFU_HALT);
    halted         = (state_q == IFU_HALT);
  end

endmodule

// File: tb/tb_ifu.sv
module tb_ifu;

  localparam int unsigned XLEN   = 64;
  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            imem_req_valid;
  logic            imem_req_ready = 1'b0;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid = 1'b0;
  logic [31:0]     imem_rsp_data = '0;
  logic            instr_valid;
  logic            instr_ready = 1'b0;
  logic [31:0]     instr;
  logic [XLEN-1:0] instr_pc;
  logic            redirect_valid = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;
  logic            halt = 1'b0;
  logic            misalign;
  logic            halted;

  always #5 clk = ~clk;

  ifu #(.XLEN(XLEN), .RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .misalign       (misalign),
    .halted         (halted)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Stimulus knobs (percent probabilities).
  int p_ready, p_redir, p_halt, p_iready, p_spur, p_misal, max_lat;
  bit use_fixed;
  logic [31:0] fixed_word;

  // Reference model: architectural next-fetch PC and the single memory transaction.
  typedef struct {
    logic [31:0] w;
    logic [63:0] pc;
  } exp_t;
  exp_t sb[$];

  logic [63:0] exp_pc;
  bit          exp_halted, exp_misal, outstanding, killed;
  int          mem_cnt;
  logic [31:0] mem_word;
  logic [63:0] mem_addr;
  int          iter, idle, hs_count, first_req, first_iv;

  function automatic logic [63:0] pick_target();
    logic [63:0] t;
    case ($urandom_range(3))
      0:       t = RST_PC + 64'({$urandom_range(255), 2'b00});
      1:       t = 64'hFFFF_FFFF_FFFF_FFF8;
      2:       t = {$urandom, $urandom};
      default: t = RST_PC + 64'h100;
    endcase
    if ($urandom_range(99) >= p_misal) t[1:0] = 2'b00;
    return t;
  endfunction

  task automatic check_outputs();
    iter++;
    if (imem_req_valid && first_req < 0) first_req = iter;
    if (instr_valid && first_iv < 0) first_iv = iter;
    if (exp_halted) begin
      chk("halted", 64'(halted), 64'd1);
      chk("halt_req_valid", 64'(imem_req_valid), 64'd0);
      chk("halt_instr_valid", 64'(instr_valid), 64'd0);
      chk("halt_misalign", 64'(misalign), 64'd0);
      chk("halt_req_addr", imem_req_addr, 64'd0);
    end else begin
      chk("halted", 64'(halted), 64'd0);
      chk("misalign", 64'(misalign), 64'(exp_misal));
      if (imem_req_valid) chk("req_addr", imem_req_addr, exp_pc);
      if (outstanding || instr_valid) chk("one_outstanding", 64'(imem_req_valid), 64'd0);
    end
  endtask

  task automatic update_model();
    logic [63:0] old_pc;
    bit hs;
    old_pc = exp_pc;
    hs = instr_valid && instr_ready;
    if (exp_halted) return;
    if (hs) hs_count++;
    if (hs && halt) begin
      exp_halted = 1'b1;
    end else begin
      if (redirect_valid) begin
        exp_misal = exp_misal | (redirect_pc[1:0] != 2'b00);
        exp_pc    = {redirect_pc[63:2], 2'b00};
      end else if (hs) begin
        exp_pc = exp_pc + 64'd4;
      end
    end
    if (imem_req_valid && imem_req_ready) begin
      outstanding = 1'b1;
      killed      = redirect_valid;
      mem_addr    = old_pc;
      mem_word    = use_fixed ? fixed_word : $urandom;
      mem_cnt     = $urandom_range(max_lat - 1);
    end else if (outstanding && imem_rsp_valid) begin
      outstanding = 1'b0;
      if (!killed && !redirect_valid) sb.push_back('{w: mem_word, pc: mem_addr});
    end else if (outstanding && redirect_valid) begin
      killed = 1'b1;
    end
    if (hs) idle = 0;
    else idle++;
    if (idle > 150) begin
      checks++;
      errors++;
      $display("FAIL watchdog: no instruction accepted for %0d cycles", idle);
      idle = 0;
    end
  endtask

  task automatic drive_cycle();
    @(posedge clk);
    #2;
    imem_req_ready = ($urandom_range(99) < p_ready);
    imem_rsp_valid = 1'b0;
    if (outstanding) begin
      if (mem_cnt == 0) imem_rsp_valid = 1'b1;
      else mem_cnt--;
      imem_rsp_data = mem_word;
    end else begin
      imem_rsp_valid = ($urandom_range(99) < p_spur);
      imem_rsp_data  = $urandom;
    end
    redirect_valid = ($urandom_range(99) < p_redir);
    redirect_pc    = pick_target();
    instr_ready    = ($urandom_range(99) < p_iready);
    halt           = ($urandom_range(99) < p_halt);
    @(negedge clk);
    check_outputs();
    update_model();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) drive_cycle();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    halt           = 1'b0;
    #1;
    // Checked before any clock edge: reset must act asynchronously.
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_req_addr", imem_req_addr, 64'd0);
    chk("rst_instr_valid", 64'(instr_valid), 64'd0);
    chk("rst_instr", 64'(instr), 64'd0);
    chk("rst_instr_pc", instr_pc, 64'd0);
    chk("rst_misalign", 64'(misalign), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    sb.delete();
    exp_pc      = RST_PC;
    exp_halted  = 1'b0;
    exp_misal   = 1'b0;
    outstanding = 1'b0;
    killed      = 1'b0;
    mem_cnt     = 0;
    iter        = 0;
    idle        = 0;
    hs_count    = 0;
    first_req   = -1;
    first_iv    = -1;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Monitor: pops the scoreboard when a new instruction is presented and
  // checks that a presented instruction holds still until it leaves.
  bit   seen = 1'b0;
  exp_t cur;
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
    end else if (instr_valid) begin
      if (!seen) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_instr: got %h at pc %h, expected none", instr, instr_pc);
        end else begin
          cur = sb.pop_front();
          chk("instr", 64'(instr), 64'(cur.w));
          chk("instr_pc", instr_pc, cur.pc);
        end
        seen = 1'b1;
      end else begin
        chk("instr_stable", 64'(instr), 64'(cur.w));
        chk("instr_pc_stable", instr_pc, cur.pc);
      end
      if (instr_ready || redirect_valid) seen = 1'b0;
    end
  end

  task automatic set_knobs(input int rdy, input int rdr, input int hlt, input int irdy,
                           input int spur, input int mis, input int lat);
    p_ready  = rdy;
    p_redir  = rdr;
    p_halt   = hlt;
    p_iready = irdy;
    p_spur   = spur;
    p_misal  = mis;
    max_lat  = lat;
  endtask

  initial begin
    use_fixed  = 1'b0;
    fixed_word = '0;
    set_knobs(100, 0, 0, 100, 0, 0, 1);

    // ebreak at the first handshake: REQ, WAIT, OUT, then stopped.
    do_reset();
    use_fixed  = 1'b1;
    fixed_word = 32'h0010_0073;
    set_knobs(100, 0, 100, 100, 0, 0, 1);
    run(10);
    chk("t1_first_req_cycle", 64'(first_req), 64'd1);
    chk("t1_first_instr_cycle", 64'(first_iv), 64'd3);
    chk("t1_halted", 64'(halted), 64'd1);
    chk("t1_handshakes", 64'(hs_count), 64'd1);
    chk("t1_sb_empty", 64'(sb.size()), 64'd0);

    // Straight-line nops: one instruction every three cycles.
    do_reset();
    fixed_word = 32'h0000_0013;
    set_knobs(100, 0, 0, 100, 0, 0, 1);
    run(20);
    chk("t2_handshakes", 64'(hs_count), 64'd6);
    chk("t2_next_pc", exp_pc, RST_PC + 64'd24);
    use_fixed = 1'b0;

    // Randomised segments with redirects, back-pressure, latency and halts.
    for (int s = 0; s < 8; s++) begin
      do_reset();
      set_knobs($urandom_range(40, 100), $urandom_range(0, 15), $urandom_range(0, 2),
                $urandom_range(30, 100), $urandom_range(0, 20), $urandom_range(0, 30),
                $urandom_range(1, 4));
      run(400);
    end

    // Reset in the middle of a wait, then stray responses after restart.
    do_reset();
    set_knobs(100, 0, 0, 100, 0, 0, 4);
    for (int i = 0; i < 50 && !(outstanding && mem_cnt > 0); i++) drive_cycle();
    chk("t6_midwait_reached", 64'(outstanding && mem_cnt > 0), 64'd1);
    do_reset();
    set_knobs(100, 0, 0, 100, 100, 0, 1);
    run(30);
    chk("t6_restarted", 64'(hs_count > 0), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
